// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: tile-grid VGA renderer with a frame-shadowed cell map and a 2-tick pixel pipeline.
// Define VGA_TILE_GRID_LINES_EN to draw cell borders using the last palette entry.
module vga_tile_renderer #(
    parameter int COLS    = 16,
    parameter int ROWS    = 12,
    parameter int BPC     = 2,
    parameter int CELL_W  = 40,
    parameter int CELL_H  = 40,
    parameter int CLK_DIV = 2,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [COLS*ROWS*BPC-1:0]    cells,
    input  logic [(2**BPC)*12-1:0]      palette,
    output logic                        hSync,
    output logic                        vSync,
    output logic [3:0]                  r,
    output logic [3:0]                  g,
    output logic [3:0]                  b,
    output logic                        frame_start,
    output logic                        active
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACT;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACT;
    localparam int N       = COLS * ROWS;
    localparam int TW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PXW     = $clog2(CELL_W + 1);
    localparam int PYW     = $clog2(CELL_H + 1);
    localparam int CXW     = $clog2(H_ACT + 1);
    localparam int CYW     = $clog2(V_ACT + 1);
    localparam int IW      = $clog2(COLS * (V_ACT + 1) + H_ACT + 1);

    logic [TW-1:0]      tick_q, tick_d;
    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    logic [PXW-1:0]     px_q, px_d;
    logic [PYW-1:0]     py_q, py_d;
    logic [CXW-1:0]     cx_q, cx_d;
    logic [CYW-1:0]     cy_q, cy_d;
    logic [IW-1:0]      row_q, row_d, idx;
    logic [N*BPC-1:0]   shadow_q;
    logic [BPC-1:0]     s1_idx_q, cell_v, pal_d;
    logic               s1_on_q, s1_vis_q, s1_hs_q, s1_vs_q;
    logic [11:0]        rgb_q, rgb_sel;
    logic               act_q, hs_q, vs_q;
    logic               pix, fs, h_last, v_last, h_vis, v_vis, px_wrap, py_wrap, line_end, in_grid;

    always_comb begin
        pix      = tick_q == TW'(CLK_DIV - 1);
        h_last   = h_q == HW'(H_TOTAL - 1);
        v_last   = v_q == VW'(V_TOTAL - 1);
        fs       = pix && h_q == '0 && v_q == '0;
        h_vis    = int'(h_q) >= H_START && int'(h_q) < H_END;
        v_vis    = int'(v_q) >= V_START && int'(v_q) < V_END;
        px_wrap  = px_q == PXW'(CELL_W - 1);
        py_wrap  = py_q == PYW'(CELL_H - 1);
        line_end = pix && h_last;
        tick_d   = pix ? '0 : tick_q + 1'b1;
        h_d      = !pix ? h_q : h_last ? '0 : h_q + 1'b1;
        v_d      = !line_end ? v_q : v_last ? '0 : v_q + 1'b1;
        px_d     = !pix ? px_q : (!h_vis || px_wrap) ? '0 : px_q + 1'b1;
        cx_d     = !pix ? cx_q : !h_vis ? '0 : cx_q + CXW'(px_wrap);
        py_d     = !line_end ? py_q : (!v_vis || py_wrap) ? '0 : py_q + 1'b1;
        cy_d     = !line_end ? cy_q : !v_vis ? '0 : cy_q + CYW'(py_wrap);
        row_d    = !line_end ? row_q : !v_vis ? '0 : py_wrap ? row_q + IW'(COLS) : row_q;
    end

    // Linear cell index built from a running row base, so the pixel path needs no multiplier.
    always_comb begin
        idx     = row_q + IW'(cx_q);
        in_grid = int'(cx_q) < COLS && int'(cy_q) < ROWS;
        cell_v  = '0;
        for (int i = 0; i < N; i++)
            if (idx == IW'(i)) cell_v = shadow_q[(N-1-i)*BPC +: BPC];
`ifdef VGA_TILE_GRID_LINES_EN
        pal_d = (px_q == '0 || py_q == '0) ? '1 : cell_v;
`else
        pal_d = cell_v;
`endif
        rgb_sel = '0;
        for (int i = 0; i < 2**BPC; i++)
            if (s1_idx_q == BPC'(i)) rgb_sel = palette[i*12 +: 12];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            {tick_q, h_q, v_q, px_q, py_q, cx_q, cy_q, row_q, shadow_q} <= '0;
            {s1_idx_q, s1_on_q, s1_vis_q, s1_hs_q, s1_vs_q} <= '0;
            {rgb_q, act_q, hs_q, vs_q} <= '0;
        end else begin
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
            px_q   <= px_d;
            py_q   <= py_d;
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            row_q  <= row_d;
            if (fs) shadow_q <= cells;
            if (pix) begin
                s1_idx_q <= pal_d;
                s1_on_q  <= h_vis && v_vis && in_grid;
                s1_vis_q <= h_vis && v_vis;
                s1_hs_q  <= int'(h_q) < H_SYNC;
                s1_vs_q  <= int'(v_q) < V_SYNC;
                rgb_q    <= s1_on_q ? rgb_sel : '0;
                act_q    <= s1_vis_q;
                hs_q     <= s1_hs_q;
                vs_q     <= s1_vs_q;
            end
        end
    end

    // Sync flags are stored active-high so cleared pipeline registers mean "no pulse".
    assign hSync       = ~(hs_q & ~reset);
    assign vSync       = ~(vs_q & ~reset);
    assign {r, g, b}   = reset ? 12'h000 : rgb_q;
    assign active      = act_q & ~reset;
    assign frame_start = fs & ~reset;
endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: scoreboard bench for vga_tile_renderer on a reduced timing so whole frames fit.
module tb_vga_tile_renderer;
    localparam int COLS = 4, ROWS = 3, BPC = 2, CELL_W = 4, CELL_H = 4, CLK_DIV = 2;
    localparam int H_SYNC = 4, H_BP = 2, H_ACT = 20, H_FP = 2;
    localparam int V_SYNC = 2, V_BP = 2, V_ACT = 16, V_FP = 2;
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int FRAME = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam int N = COLS * ROWS;
    localparam int CW = N * BPC;
    localparam int HS0 = H_SYNC + H_BP;
    localparam int VS0 = V_SYNC + V_BP;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [CW-1:0] cells = '0;
    logic [(2**BPC)*12-1:0] palette = {12'h0AF, 12'h5A5, 12'hF00, 12'h000};
    logic hSync, vSync, frame_start, active;
    logic [3:0] r, g, b;

    int checks = 0;
    int errors = 0;
    int m_tick = 0, m_h = 0, m_v = 0;
    int n;
    logic [CW-1:0] m_sh = '0;
    logic [14:0] sbq[$];
    logic [14:0] exp_px;
    logic fs_exp;

    vga_tile_renderer #(
        .COLS(COLS), .ROWS(ROWS), .BPC(BPC), .CELL_W(CELL_W), .CELL_H(CELL_H), .CLK_DIV(CLK_DIV),
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP)
    ) dut (
        .clock(clk), .reset(reset), .cells(cells), .palette(palette),
        .hSync(hSync), .vSync(vSync), .r(r), .g(g), .b(b),
        .frame_start(frame_start), .active(active)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] model_px(int h, int v);
        int x, y, ci;
        logic [BPC-1:0] pi;
        logic [11:0] c;
        logic vis;
        x = h - HS0;
        y = v - VS0;
        vis = x >= 0 && x < H_ACT && y >= 0 && y < V_ACT;
        c = '0;
        if (vis && x / CELL_W < COLS && y / CELL_H < ROWS) begin
            ci = (y / CELL_H) * COLS + x / CELL_W;
            pi = BPC'(m_sh >> ((N - 1 - ci) * BPC));
`ifdef VGA_TILE_GRID_LINES_EN
            if (x % CELL_W == 0 || y % CELL_H == 0) pi = '1;
`endif
            c = 12'(palette >> (int'(pi) * 12));
        end
        return {h >= H_SYNC, v >= V_SYNC, vis, c};
    endfunction

    // Reference timing model: pushes each pixel as it enters the DUT, compares two ticks later.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            assert ({hSync, vSync, active, frame_start, r, g, b} === 16'hC000) else begin
                errors++;
                $error("FAIL reset_outputs got %h exp %h", {hSync, vSync, active, frame_start, r, g, b}, 16'hC000);
            end
            m_tick = 0; m_h = 0; m_v = 0; m_sh = '0;
            sbq.delete();
        end else begin
            fs_exp = m_tick == CLK_DIV - 1 && m_h == 0 && m_v == 0;
            checks++;
            assert (frame_start === fs_exp) else begin
                errors++;
                $error("FAIL frame_start h=%0d v=%0d got %b exp %b", m_h, m_v, frame_start, fs_exp);
            end
            if (m_tick == CLK_DIV - 1) begin
                if (sbq.size() == 2) begin
                    exp_px = sbq.pop_front();
                    checks++;
                    assert ({hSync, vSync, active, r, g, b} === exp_px) else begin
                        errors++;
                        $error("FAIL pixel h=%0d v=%0d got %h exp %h", m_h, m_v, {hSync, vSync, active, r, g, b}, exp_px);
                    end
                end
                sbq.push_back(model_px(m_h, m_v));
                if (fs_exp) m_sh = cells;
                m_tick = 0;
                if (m_h == H_TOTAL - 1) begin
                    m_h = 0;
                    m_v = m_v == V_TOTAL - 1 ? 0 : m_v + 1;
                end else m_h++;
            end else m_tick++;
        end
    end

    task automatic wait_fs(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (frame_start !== 1'b1 && cnt < 4 * FRAME);
        checks++;
        assert (frame_start === 1'b1) else begin
            errors++;
            $error("FAIL fs_timeout got %b exp 1 after %0d clocks", frame_start, cnt);
        end
    endtask

    task automatic check_count(string tag, int got, int expv);
        checks++;
        assert (got == expv) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, expv);
        end
    endtask

    task automatic drive_cells(logic [CW-1:0] val);
        @(posedge clk);
        #1 cells = val;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_fs(n);
        check_count("first_fs_latency", n, CLK_DIV);
        wait_fs(n);
        check_count("frame_period", n, FRAME);

        drive_cells({2'b01, {(CW-2){1'b0}}});
        wait_fs(n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (active !== 1'b1 && n < FRAME);
        checks++;
`ifdef VGA_TILE_GRID_LINES_EN
        assert ({r, g, b} === 12'h0AF) else begin
            errors++;
            $error("FAIL first_visible got %h exp %h", {r, g, b}, 12'h0AF);
        end
`else
        assert ({r, g, b} === 12'hF00) else begin
            errors++;
            $error("FAIL first_visible got %h exp %h", {r, g, b}, 12'hF00);
        end
`endif
        wait_fs(n);

        drive_cells(CW'(3));
        wait_fs(n);
        wait_fs(n);

        drive_cells(CW'($urandom()));
        wait_fs(n);
        repeat (500) @(posedge clk);
        #1 cells = ~cells;
        wait_fs(n);
        wait_fs(n);

        drive_cells({N{2'b01}});
        wait_fs(n);
        wait_fs(n);

        repeat (317) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_fs(n);
        check_count("post_reset_fs_latency", n, CLK_DIV);
        wait_fs(n);
        check_count("post_reset_frame_period", n, FRAME);
        drive_cells(CW'($urandom()));
        wait_fs(n);
        wait_fs(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_tile_renderer.md
VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

Interface
REQ-001 Parameter COLS, default 16: grid columns.
REQ-002 Parameter ROWS, default 12: grid rows.
REQ-003 Parameter BPC, default 2: bits per cell, as a palette index.
REQ-004 Parameter CELL_W / CELL_H, default 40 / 40: cell size in pixels.
REQ-005 Parameter CLK_DIV, default 2: system clocks per pixel tick; must be ≥1.
REQ-006 Parameters H_SYNC/H_BP/H_ACT/H_FP, default 96/48/640/16; V_SYNC/V_BP/V_ACT/V_FP, default 2/33/480/10.
REQ-007 clock  in  1  system clock; single clock domain; all logic on the rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 cells  in  COLS*ROWS*BPC  flattened grid; cell (x,y) = bits [(COLS*ROWS-1-(y*COLS+x))*BPC +: BPC], so the top-left cell is in the MSBs.
REQ-010 palette  in  (2**BPC)*12  entry i = bits [i*12 +: 12], laid out as {R[3:0],G[3:0],B[3:0]}.
REQ-011 hSync, vSync  out  1 each  active-low sync pulses.
REQ-012 r, g, b  out  4 each  colour outputs.
REQ-013 frame_start  out  1  one-clock pulse at the start of each frame.
REQ-014 active  out  1  high while r/g/b carry visible pixels.

Function
REQ-015 Tick counter runs 0..CLK_DIV-1; pixel tick = counter at CLK_DIV-1; all counters and outputs advance only on a pixel tick.
REQ-016 h_count runs 0..H_TOTAL-1 (H_TOTAL = sum of H params), then wraps to 0.
REQ-017 v_count increments only when h_count wraps; it wraps to 0 only on the tick where h_count=H_TOTAL-1 and v_count=V_TOTAL-1.
REQ-018 Raw sync: h_count<H_SYNC gives hSync low; v_count<V_SYNC gives vSync low.
REQ-019 Visible window: h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT); v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
REQ-020 Cell coordinates use sub-counters with no dividers or multipliers in the pixel path:
- px_in_cell counts 0..CELL_W-1, and cx increments on its wrap; both clear at the start of each visible line.
- py_in_cell and cy are updated the same way per visible line, and clear at the start of each frame.
REQ-021 Pixels where cx≥COLS or cy≥ROWS are black (0,0,0).
REQ-022 Shadow register: cells is copied into a shadow register on the pixel tick where h_count=0 and v_count=0. Rendering reads only the shadow, so no tearing occurs mid-frame.
REQ-023 frame_start is asserted for exactly one clock, on that same latch tick.
REQ-024 Pipeline is 2 ticks:
- stage 1: registered cell index lookup;
- stage 2: registered palette lookup to r/g/b.
hSync, vSync and active are delayed through matching 2-stage registers so all outputs stay aligned.
REQ-025 Outside the visible window, r/g/b = 0 and active = 0.
REQ-026 Changes to palette take effect on the next pixel tick; palette is not shadowed.

Reset
REQ-027 Reset clears all counters, sub-counters, pipeline registers and the shadow register to 0, on the next rising clock edge.
REQ-028 While reset is high, outputs are: hSync=1, vSync=1, r=g=b=0, active=0, frame_start=0.
REQ-029 After reset deasserts, the first pixel tick occurs CLK_DIV clocks later with h_count=0 and v_count=0. That tick latches cells and pulses frame_start.
REQ-030 Reset asserted mid-frame abandons the frame immediately; no partial-line continuation.

Configuration
REQ-031 Macro VGA_TILE_GRID_LINES_EN controls grid-line drawing.
- Defined: visible pixels with px_in_cell=0 or py_in_cell=0, inside the grid, output palette entry 2**BPC-1 regardless of cell value.
- Undefined: no grid lines; no extra logic.

Verification
REQ-032 Defaults, cells all 0:
- hSync period = 1600 clocks, low for 192 clocks.
- vSync period = 840000 clocks, low for 3200 clocks.
- frame_start pulses once per 840000 clocks.
REQ-033 Defaults, only cell (0,0)=1, palette[1]=12'hF00:
- first visible pixel → r=F, g=0, b=0;
- visible pixel 40 of line 0 → r=g=b=0;
- visible line 40, pixel 0 → r=g=b=0.
REQ-034 Defaults, only cell (15,11)=3, palette[3]=12'h0AF → the last visible pixel of the frame is r=0, g=A, b=F, and the pixel 40 to its left is black.
REQ-035 cells changed mid-frame → current frame output unchanged; new value appears from the next frame_start.
REQ-036 COLS=4, ROWS=3, CELL_W=CELL_H=40, cells all 1, palette[1]=12'hFFF → pixels with x≥160 or y≥120 are black; the rest are white.
REQ-037 Reset asserted for 3 clocks mid-line → outputs take reset values during reset. After release, the next frame_start occurs exactly 840000 clocks after the first post-reset frame_start. With VGA_TILE_GRID_LINES_EN, pixel x=40, y=5 shows palette[3].
